perft_sequencer: RTL and testbench

PERFT_SEQUENCER -- requirements
Module: perft_sequencer

---
 rtl/perft_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_perft_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perft_sequencer.sv
// perft_sequencer: walks a perft move tree through gen/make/undo handshakes and counts leaf nodes.
// Latency: data dependent, one handshake per tree edge; the last ply is counted in bulk from gen_count.
// Backpressure: each req is held until its ack; REPORT stalls the walk until root_ready. PERFT_TIMER_EN adds cycle_count.
module perft_sequencer #(
  parameter int MAX_DEPTH = 8,
  parameter int NODE_W    = 48,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        depth,
  output logic              busy,
  output logic              done,
  output logic              gen_req,
  input  logic              gen_ack,
  input  logic [IDX_W-1:0]  gen_count,
  output logic              mk_req,
  output logic [IDX_W-1:0]  mk_idx,
  input  logic              mk_ack,
  output logic              un_req,
  input  logic              un_ack,
  output logic              root_valid,
  output logic [IDX_W-1:0]  root_idx,
  output logic [NODE_W-1:0] root_nodes,
  input  logic              root_ready,
  output logic [NODE_W-1:0] total_nodes,
  output logic              ovf
`ifdef PERFT_TIMER_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int SW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [IDX_W-1:0]  ONE_I = 1;
  localparam logic [NODE_W:0]   ONE_N = 1;
  localparam logic [SW-1:0]     ROOT  = '0;

  typedef enum logic [2:0] {IDLE, GEN, MAKE, DESCEND, UNDO, REPORT, FIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt_stk [MAX_DEPTH];
  logic [IDX_W-1:0]  nxt_stk [MAX_DEPTH];
  logic [3:0]        ply;
  logic [3:0]        depth_r;
  logic [NODE_W-1:0] root_base;

  logic [3:0]        rem;
  logic [3:0]        up;
  logic [SW-1:0]     p_idx;
  logic [SW-1:0]     u_idx;
  logic [IDX_W-1:0]  up_next;
  logic [IDX_W-1:0]  root_next;
  logic [NODE_W:0]   sum_one;
  logic [NODE_W:0]   sum_cnt;
  logic [3:0]        depth_clamped;

  // Stack addressing, next-index arithmetic and carry-extended node sums
  always_comb begin
    rem           = depth_r - ply;
    up            = ply - 4'd1;
    p_idx         = ply[SW-1:0];
    u_idx         = up[SW-1:0];
    up_next       = nxt_stk[u_idx] + ONE_I;
    root_next     = nxt_stk[ROOT] + ONE_I;
    sum_one       = {1'b0, total_nodes} + ONE_N;
    sum_cnt       = {1'b0, total_nodes} + {{(NODE_W + 1 - IDX_W){1'b0}}, gen_count};
    depth_clamped = (depth > 4'(MAX_DEPTH)) ? 4'(MAX_DEPTH) : depth;
  end

  // Tree walk: one state per handshake phase, every output registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ply         <= 4'd0;
      depth_r     <= 4'd0;
      root_base   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      gen_req     <= 1'b0;
      mk_req      <= 1'b0;
      mk_idx      <= '0;
      un_req      <= 1'b0;
      root_valid  <= 1'b0;
      root_idx    <= '0;
      root_nodes  <= '0;
      total_nodes <= '0;
      ovf         <= 1'b0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        cnt_stk[i] <= '0;
        nxt_stk[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ply         <= 4'd0;
            depth_r     <= depth_clamped;
            total_nodes <= '0;
            ovf         <= 1'b0;
            if (depth == 4'd0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              busy    <= 1'b1;
              gen_req <= 1'b1;
              state   <= GEN;
            end
          end
        end
        GEN: begin
          if (gen_ack) begin
            gen_req <= 1'b0;
            if (ply != 4'd0 && rem == 4'd1) begin
              // Last interior ply: the move count is the leaf count
              total_nodes <= sum_cnt[NODE_W-1:0];
              if (sum_cnt[NODE_W]) ovf <= 1'b1;
              un_req <= 1'b1;
              state  <= UNDO;
            end else if (gen_count == '0) begin
              if (ply == 4'd0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                un_req <= 1'b1;
                state  <= UNDO;
              end
            end else begin
              cnt_stk[p_idx] <= gen_count;
              nxt_stk[p_idx] <= '0;
              mk_idx         <= '0;
              mk_req         <= 1'b1;
              if (ply == 4'd0) root_base <= total_nodes;
              state <= MAKE;
            end
          end
        end
        MAKE: begin
          if (mk_ack) begin
            mk_req <= 1'b0;
            ply    <= ply + 4'd1;
            state  <= DESCEND;
          end
        end
        DESCEND: begin
          if (rem == 4'd0) begin
            total_nodes <= sum_one[NODE_W-1:0];
            if (sum_one[NODE_W]) ovf <= 1'b1;
            un_req <= 1'b1;
            state  <= UNDO;
          end else begin
            gen_req <= 1'b1;
            state   <= GEN;
          end
        end
        UNDO: begin
          // Chained undos re-enter with un_req low so each request is a fresh pulse
          if (!un_req) begin
            un_req <= 1'b1;
          end else if (un_ack) begin
            un_req <= 1'b0;
            ply    <= up;
            if (up == 4'd0) begin
              root_valid <= 1'b1;
              root_idx   <= nxt_stk[ROOT];
              root_nodes <= total_nodes - root_base;
              state      <= REPORT;
            end else if (up_next < cnt_stk[u_idx]) begin
              nxt_stk[u_idx] <= up_next;
              mk_idx         <= up_next;
              mk_req         <= 1'b1;
              state          <= MAKE;
            end else begin
              state <= UNDO;
            end
          end
        end
        REPORT: begin
          if (root_ready) begin
            root_valid <= 1'b0;
            if (root_next < cnt_stk[ROOT]) begin
              nxt_stk[ROOT] <= root_next;
              mk_idx        <= root_next;
              mk_req        <= 1'b1;
              root_base     <= total_nodes;
              state         <= MAKE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PERFT_TIMER_EN
  // Run timer: restarts on an accepted start, counts busy cycles, holds after done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state == IDLE && start) begin
      cycle_count <= '0;
    end else if (busy) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_perft_sequencer.sv
// tb_perft_sequencer: randomized host model driving perft_sequencer against a per-ply leaf-count model.
// Move counts come from a table indexed by (ply, last move index); expectations are built bottom-up.
// Acks are delayed by a per-run latency; root_ready is constant, random, or stalled on the first report.
module tb_perft_sequencer;
  localparam int NW = 10;
  localparam int IW = 8;
  localparam int MD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    depth = 4'd0;
  logic          busy, done;
  logic          gen_req, mk_req, un_req;
  logic          gen_ack = 1'b0, mk_ack = 1'b0, un_ack = 1'b0;
  logic [IW-1:0] gen_count = '0;
  logic [IW-1:0] mk_idx;
  logic          root_valid;
  logic [IW-1:0] root_idx;
  logic [NW-1:0] root_nodes;
  logic          root_ready = 1'b0;
  logic [NW-1:0] total_nodes;
  logic          ovf;
`ifdef PERFT_TIMER_EN
  logic [31:0]   cycle_count;
`endif

  perft_sequencer #(.MAX_DEPTH(MD), .NODE_W(NW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .depth(depth),
    .busy(busy), .done(done),
    .gen_req(gen_req), .gen_ack(gen_ack), .gen_count(gen_count),
    .mk_req(mk_req), .mk_idx(mk_idx), .mk_ack(mk_ack),
    .un_req(un_req), .un_ack(un_ack),
    .root_valid(root_valid), .root_idx(root_idx), .root_nodes(root_nodes),
    .root_ready(root_ready), .total_nodes(total_nodes), .ovf(ovf)
`ifdef PERFT_TIMER_EN
    , .cycle_count(cycle_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cnt_tbl [0:8][0:31];
  longint m_leaf  [0:8][0:31];
  int     m_gen   [0:8][0:31];
  int     m_mk    [0:8][0:31];
  int     path[$];
  int     rep_idx[$];
  longint rep_nodes[$];
  int     n_gen = 0, n_mk = 0, n_un = 0;
  int     proto_viol = 0, stall_viol = 0, done_cnt = 0, busy_cyc = 0;
  int     ack_lat = 0, ready_mode = 0;
  bit     stall_armed = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(input int v);
    for (int p = 0; p <= 8; p++)
      for (int l = 0; l < 32; l++) cnt_tbl[p][l] = v;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int p = 0; p <= 8; p++)
      for (int l = 0; l < 32; l++) cnt_tbl[p][l] = int'($urandom_range(hi, lo));
  endtask

  // Leaves, generations and makes below every (ply, last move) node, deepest ply first
  task automatic build_model(input int dd);
    for (int p = dd; p >= 0; p--) begin
      for (int l = 0; l < 32; l++) begin
        int r;
        int c;
        r = dd - p;
        c = cnt_tbl[p][l];
        if (p >= 1 && r == 0) begin
          m_leaf[p][l] = 1; m_gen[p][l] = 0; m_mk[p][l] = 0;
        end else if (p >= 1 && r == 1) begin
          m_leaf[p][l] = c; m_gen[p][l] = 1; m_mk[p][l] = 0;
        end else begin
          m_leaf[p][l] = 0; m_gen[p][l] = 1; m_mk[p][l] = c;
          for (int i = 0; i < c; i++) begin
            m_leaf[p][l] += m_leaf[p+1][i];
            m_gen[p][l]  += m_gen[p+1][i];
            m_mk[p][l]   += m_mk[p+1][i];
          end
        end
      end
    end
  endtask

  // Host model: answers requests after ack_lat cycles and tracks the move path
  initial begin : responder
    int wait_n;
    bit prev_mk;
    logic [IW-1:0] prev_idx;
    wait_n = 0; prev_mk = 1'b0; prev_idx = '0;
    forever begin
      @(negedge clk);
      gen_ack = 1'b0; mk_ack = 1'b0; un_ack = 1'b0;
      gen_count = IW'($urandom);
      if (!rst_n) begin
        path.delete();
        wait_n = 0; prev_mk = 1'b0;
      end else begin
        if (int'(gen_req) + int'(mk_req) + int'(un_req) > 1) proto_viol++;
        if (mk_req && prev_mk && mk_idx != prev_idx) proto_viol++;
        prev_mk = mk_req; prev_idx = mk_idx;
        if (gen_req || mk_req || un_req) begin
          if (wait_n >= ack_lat) begin
            wait_n = 0; prev_mk = 1'b0;
            if (gen_req) begin
              int ply;
              int last;
              ply  = path.size();
              last = (ply == 0) ? 0 : path[$];
              gen_count = (ply <= 8 && last < 32) ? IW'(cnt_tbl[ply][last]) : '0;
              gen_ack = 1'b1;
              n_gen++;
            end else if (mk_req) begin
              path.push_back(int'(mk_idx));
              mk_ack = 1'b1;
              n_mk++;
            end else begin
              if (path.size() > 0) void'(path.pop_back());
              un_ack = 1'b1;
              n_un++;
            end
          end else begin
            wait_n++;
          end
        end else begin
          wait_n = 0;
        end
      end
    end
  end

  // Result consumer: drives root_ready, watches the stall hold, collects reports
  initial begin : collector
    bit holding;
    int stall_left;
    logic [IW-1:0] snap_idx;
    logic [NW-1:0] snap_nodes;
    holding = 1'b0; stall_left = 0; snap_idx = '0; snap_nodes = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0; stall_left = 0; root_ready = 1'b0;
      end else if (root_valid) begin
        if (!holding) begin
          holding = 1'b1; snap_idx = root_idx; snap_nodes = root_nodes;
          stall_left = stall_armed ? 10 : 0;
          stall_armed = 1'b0;
        end
        if (root_idx != snap_idx || root_nodes != snap_nodes) stall_viol++;
        if (mk_req) stall_viol++;
        if (stall_left > 0) begin
          root_ready = 1'b0;
          stall_left--;
        end else begin
          root_ready = (ready_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b1;
          if (root_ready) begin
            rep_idx.push_back(int'(root_idx));
            rep_nodes.push_back(longint'(root_nodes));
            holding = 1'b0;
          end
        end
      end else begin
        root_ready = (ready_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
    end
  end

  // Pulse and busy-cycle counters
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (busy) busy_cyc++;
  end

  task automatic clear_stats();
    n_gen = 0; n_mk = 0; n_un = 0;
    proto_viol = 0; stall_viol = 0; done_cnt = 0; busy_cyc = 0;
    rep_idx.delete(); rep_nodes.delete();
  endtask

  task automatic run_case(input string nm, input int d, input int lat, input int rmode);
    int dd, cyc, c0, nr;
    longint exp_total, mask;
    dd = (d > MD) ? MD : d;
    mask = (longint'(1) << NW) - 1;
    if (dd > 0) build_model(dd);
    exp_total = (dd == 0) ? 0 : m_leaf[0][0];
    c0 = (dd == 0) ? 0 : cnt_tbl[0][0];
    clear_stats();
    ack_lat = lat; ready_mode = rmode; stall_armed = (rmode == 2);
    @(negedge clk);
    start = 1'b1; depth = 4'(d);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, ".done"}, longint'(done), 1);
    check({nm, ".busy_at_done"}, longint'(busy), 0);
    repeat (2) @(negedge clk);
    check({nm, ".total"}, longint'(total_nodes), exp_total & mask);
    check({nm, ".ovf"}, longint'(ovf), longint'(exp_total > mask));
    check({nm, ".done_pulses"}, done_cnt, 1);
    check({nm, ".n_reports"}, rep_idx.size(), c0);
    nr = (rep_idx.size() < c0) ? rep_idx.size() : c0;
    for (int i = 0; i < nr; i++) begin
      check({nm, ".root_idx"}, rep_idx[i], i);
      check({nm, ".root_nodes"}, rep_nodes[i], m_leaf[1][i] & mask);
    end
    check({nm, ".gens"}, n_gen, (dd == 0) ? 0 : m_gen[0][0]);
    check({nm, ".makes"}, n_mk, (dd == 0) ? 0 : m_mk[0][0]);
    check({nm, ".undos"}, n_un, n_mk);
    check({nm, ".path_empty"}, path.size(), 0);
    check({nm, ".protocol"}, proto_viol, 0);
    check({nm, ".report_hold"}, stall_viol, 0);
`ifdef PERFT_TIMER_EN
    check({nm, ".cycle_count"}, longint'(cycle_count), busy_cyc);
`endif
  endtask

  initial begin : main
    int cyc;
    #12;
    check("reset.outputs", longint'({busy, done, gen_req, mk_req, un_req, root_valid, mk_idx,
                                     root_idx, root_nodes, total_nodes, ovf}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_const(20);  run_case("d1_c20", 1, 0, 0);
    fill_const(20);  run_case("d2_c20", 2, 1, 0);

    fill_const(5);
    cnt_tbl[0][0] = 2; cnt_tbl[1][0] = 0; cnt_tbl[1][1] = 3;
    run_case("d3_dir", 3, 0, 0);

    fill_rand(1, 3); run_case("d2_stall", 2, 0, 2);
    fill_const(4);   run_case("d0", 0, 0, 0);
    fill_const(1);   run_case("clamp", 12, 0, 1);
    fill_const(2); cnt_tbl[0][0] = 0;
    run_case("root_term", 3, 1, 0);
    fill_const(12);  run_case("wrap", 3, 0, 0);

    for (int k = 0; k < 6; k++) begin
      fill_rand(0, 3);
      run_case("rand", int'($urandom_range(4, 1)), int'($urandom_range(2, 0)), 1);
    end

    // Reset while a generation request is outstanding
    fill_rand(1, 3);
    clear_stats(); ack_lat = 1; ready_mode = 0;
    @(negedge clk);
    start = 1'b1; depth = 4'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(gen_req && n_gen >= 2) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst.gen_req", longint'(gen_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.outputs", longint'({busy, done, gen_req, mk_req, un_req, root_valid, mk_idx,
                                      root_idx, root_nodes, total_nodes, ovf}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fill_const(3);   run_case("post_rst", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
